// File: rtl/fft_r2_butterfly_tw.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on Q7.8 complex samples.
// Define FFT_BFLY_SCALE_EN to halve X and Y (round half-up) before saturation.
module fft_r2_butterfly_tw #(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a_re,
    input  logic [DW-1:0] in_a_im,
    input  logic [DW-1:0] in_b_re,
    input  logic [DW-1:0] in_b_im,
    input  logic [AW-1:0] in_tw_idx,
    output logic [AW-1:0] tw_addr,
    input  logic [DW-1:0] tw_re,
    input  logic [DW-1:0] tw_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_x_re,
    output logic [DW-1:0] out_x_im,
    output logic [DW-1:0] out_y_re,
    output logic [DW-1:0] out_y_im,
    output logic          sat_flag,
    input  logic          clr_sat
);
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 3;
    localparam logic signed [SW-1:0] HALF = SW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

    logic advance, accept;
    logic [AW-1:0] addr_q;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    // Holding the last address during a stall makes the ROM re-read S1's word.
    assign tw_addr  = accept ? in_tw_idx : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         addr_q <= '0;
        else if (accept) addr_q <= in_tw_idx;
    end

    // S1: operand capture, ROM word arrives alongside
    logic                 s1_vld;
    logic signed [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_br  <= '0;
            s1_bi  <= '0;
        end else if (advance) begin
            s1_vld <= accept;
            s1_ar  <= $signed(in_a_re);
            s1_ai  <= $signed(in_a_im);
            s1_br  <= $signed(in_b_re);
            s1_bi  <= $signed(in_b_im);
        end
    end

    // S2: full-precision partial products
    logic                 s2_vld;
    logic signed [DW-1:0] s2_ar, s2_ai;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_ar  <= '0;
            s2_ai  <= '0;
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
        end else if (advance) begin
            s2_vld <= s1_vld;
            s2_ar  <= s1_ar;
            s2_ai  <= s1_ai;
            p_rr   <= s1_br * $signed(tw_re);
            p_ii   <= s1_bi * $signed(tw_im);
            p_ri   <= s1_br * $signed(tw_im);
            p_ir   <= s1_bi * $signed(tw_re);
        end
    end

    // S3: complex product, round, sum/difference, optional halving, clip
    function automatic logic [DW:0] clip(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
`ifdef FFT_BFLY_SCALE_EN
        s = (v + SW'(1)) >>> 1;
`else
        s = v;
`endif
        if (s > MAXV)      clip = {1'b1, DW'(MAXV)};
        else if (s < MINV) clip = {1'b1, DW'(MINV)};
        else               clip = {1'b0, DW'(s)};
    endfunction

    logic signed [SW-1:0] pr, pi, wbr, wbi;
    logic [DW:0] cxr, cxi, cyr, cyi;
    logic        sat_any;

    always_comb begin
        pr      = SW'(p_rr) - SW'(p_ii);
        pi      = SW'(p_ri) + SW'(p_ir);
        wbr     = (pr + HALF) >>> FRAC;
        wbi     = (pi + HALF) >>> FRAC;
        cxr     = clip(SW'(s2_ar) + wbr);
        cxi     = clip(SW'(s2_ai) + wbi);
        cyr     = clip(SW'(s2_ar) - wbr);
        cyi     = clip(SW'(s2_ai) - wbi);
        sat_any = cxr[DW] | cxi[DW] | cyr[DW] | cyi[DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x_re  <= '0;
            out_x_im  <= '0;
            out_y_re  <= '0;
            out_y_im  <= '0;
        end else if (advance) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_x_re <= cxr[DW-1:0];
                out_x_im <= cxi[DW-1:0];
                out_y_re <= cyr[DW-1:0];
                out_y_im <= cyi[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            sat_flag <= 1'b0;
        else if (advance & s2_vld & sat_any) sat_flag <= 1'b1;
        else if (clr_sat)                   sat_flag <= 1'b0;
    end
endmodule

// File: tb/tb_fft_r2_butterfly_tw.sv
// Scoreboard bench for fft_r2_butterfly_tw (default build, no output scaling).
module tb_fft_r2_butterfly_tw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic [4:0]  in_tw_idx = '0, tw_addr;
    logic [15:0] tw_re = '0, tw_im = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] out_x_re, out_x_im, out_y_re, out_y_im;
    logic        sat_flag, clr_sat = 1'b0;

    fft_r2_butterfly_tw dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .in_tw_idx(in_tw_idx), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
        .sat_flag(sat_flag), .clr_sat(clr_sat)
    );

    always #5 clk = ~clk;

    // Twiddle ROM model: registered read, indices 28..31 read as zero
    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];
    always @(posedge clk) begin
        tw_re <= rom_re[tw_addr];
        tw_im <= rom_im[tw_addr];
    end

    typedef struct {
        logic [15:0] ar, ai, br, bi;
        logic [4:0]  idx;
        logic [63:0] exp;   // {x_re, x_im, y_re, y_im}
    } vec_t;
    vec_t vt [13];

    logic [63:0] sb [$];
    int          ncmp = 0, nerr = 0;
    logic [4:0]  last_idx = '0;
    bit          burst = 1'b0;
    int          ph = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        ncmp++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Downstream back-pressure: 1,0,0,1,0,0... during the burst
    always @(posedge clk) begin
        #1;
        if (burst) begin
            out_ready = (ph % 3 == 0);
            ph++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: pop and compare on each output handshake; check stall behaviour
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {out_x_re, out_x_im, out_y_re, out_y_im}, 64'hx);
            end else begin
                chk("result", {out_x_re, out_x_im, out_y_re, out_y_im}, sb.pop_front());
            end
        end
        if (!rst && out_valid && !out_ready) begin
            chk("in_ready_stall", 64'(in_ready), 64'd0);
            chk("tw_addr_stall", 64'(tw_addr), 64'(last_idx));
        end
    end

    task automatic send(input int v);
        bit acc = 1'b0;
        in_valid  = 1'b1;
        in_a_re   = vt[v].ar;
        in_a_im   = vt[v].ai;
        in_b_re   = vt[v].br;
        in_b_im   = vt[v].bi;
        in_tw_idx = vt[v].idx;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                chk("tw_addr_issue", 64'(tw_addr), 64'(vt[v].idx));
                sb.push_back(vt[v].exp);
                last_idx = vt[v].idx;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = (i < 28) ? 16'h00B5 : 16'h0000;
            rom_im[i] = (i < 28) ? 16'hFF4B : 16'h0000;
        end
        rom_re[0] = 16'h0100; rom_im[0] = 16'h0000;   // +1
        rom_re[1] = 16'h0000; rom_im[1] = 16'hFF00;   // -j
        rom_re[2] = 16'h0080; rom_im[2] = 16'h0000;   // +0.5

        vt[0]  = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 5'd0,  {16'h0200, 16'h0000, 16'h0000, 16'h0000}};
        vt[1]  = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 5'd1,  {16'h0000, 16'hFF00, 16'h0000, 16'h0100}};
        vt[2]  = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 5'd0,  {16'h7FFF, 16'h0000, 16'h0000, 16'h0000}};
        vt[3]  = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 5'd2,  {16'h0001, 16'h0000, 16'hFFFF, 16'h0000}};
        vt[4]  = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 5'd0,  {16'h0040, 16'h0060, 16'hFFE0, 16'hFFE0}};
        vt[5]  = '{16'h0100, 16'h0100, 16'h0200, 16'h0100, 5'd1,  {16'h0200, 16'hFF00, 16'h0000, 16'h0300}};
        vt[6]  = '{16'h0005, 16'hFFFB, 16'h0100, 16'h0100, 5'd28, {16'h0005, 16'hFFFB, 16'h0005, 16'hFFFB}};
        vt[7]  = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 5'd2,  {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vt[8]  = '{16'h8000, 16'h0000, 16'h0100, 16'h0000, 5'd0,  {16'h8100, 16'h0000, 16'h8000, 16'h0000}};
        vt[9]  = '{16'h1234, 16'h0000, 16'h0000, 16'h0200, 5'd0,  {16'h1234, 16'h0200, 16'h1234, 16'hFE00}};
        vt[10] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 5'd2,  {16'h0003, 16'h0004, 16'hFFFF, 16'h0000}};
        vt[11] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 5'd1,  {16'h0100, 16'hFF00, 16'h0100, 16'h0100}};
        vt[12] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 5'd3,  {16'h0100, 16'h0000, 16'h0100, 16'h0000}};
        // vt[12] is filled in the reset test only to have a distinct in-flight index
        vt[12].exp = 64'h0;

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sat_flag",  64'(sat_flag),  64'd0);
        chk("reset_tw_addr",   64'(tw_addr),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        send(0); send(1); drain();
        chk("sat_clear_after_nonsat", 64'(sat_flag), 64'd0);
        send(2); drain();
        chk("sat_set", 64'(sat_flag), 64'd1);
        clr_sat = 1'b1; @(posedge clk); #1; clr_sat = 1'b0;
        chk("sat_cleared", 64'(sat_flag), 64'd0);
        send(3); drain();

        burst = 1'b1;
        for (int v = 4; v < 12; v++) send(v);
        drain();
        burst = 1'b0;
        chk("burst_all_delivered", 64'(sb.size()), 64'd0);
        chk("sat_set_burst", 64'(sat_flag), 64'd1);

        send(4); send(5); send(12);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sat_flag",  64'(sat_flag),  64'd0);
        chk("midrst_tw_addr",   64'(tw_addr),   64'd0);
        sb.delete();
        last_idx = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0); drain();
        chk("post_reset_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
